register_dump_streamer: RTL and testbench



---
 rtl/register_dump_streamer.sv | 122 ++++++++++++
 tb/tb_register_dump_streamer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/register_dump_streamer.sv
// Snapshots the 256-bit register bus on request and streams it out bytewise:
// sync byte, R0..R31, then a checksum byte when REG_DUMP_CHECKSUM_EN is defined.
module register_dump_streamer #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic         clock,
   input  logic         clr_n,
   input  logic [255:0] all_registers,
   input  logic         dump_req,
   output logic         busy,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         dump_done
);

   // state | meaning
   // IDLE  | waiting for dump_req; snapshot taken on the request edge
   // SYNC  | offering SYNC_BYTE
   // DATA  | offering snapshot byte R(idx)
   // CSUM  | offering mod-256 sum of R0..R31 (checksum builds only)
   // DONE  | one-cycle dump_done pulse, then back to IDLE
`ifdef REG_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, SYNC, DATA, CSUM, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, SYNC, DATA, DONE} state_t;
`endif

   state_t         state;
   logic [255:0]   snapshot;
   logic [4:0]     idx;
   logic [4:0]     idx_nxt;
   logic           xfer;

   assign xfer    = tx_valid & tx_ready;
   assign idx_nxt = idx + 5'd1;

`ifdef REG_DUMP_CHECKSUM_EN
   logic [7:0] csum;
   logic [7:0] csum_sum;
   assign csum_sum = csum + tx_data;
`endif

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         snapshot  <= '0;
         idx       <= '0;
         busy      <= 1'b0;
         tx_data   <= 8'h00;
         tx_valid  <= 1'b0;
         dump_done <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         csum      <= 8'h00;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (dump_req) begin
                  snapshot <= all_registers;
                  idx      <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                  csum     <= 8'h00;
`endif
                  busy     <= 1'b1;
                  tx_data  <= SYNC_BYTE;
                  tx_valid <= 1'b1;
                  state    <= SYNC;
               end
            end
            SYNC: begin
               if (xfer) begin
                  idx     <= '0;
                  tx_data <= snapshot[7:0];
                  state   <= DATA;
               end
            end
            DATA: begin
               if (xfer) begin
                  idx <= idx_nxt;
`ifdef REG_DUMP_CHECKSUM_EN
                  csum <= csum_sum;
`endif
                  if (idx == 5'd31) begin
`ifdef REG_DUMP_CHECKSUM_EN
                     tx_data <= csum_sum;
                     state   <= CSUM;
`else
                     tx_valid  <= 1'b0;
                     dump_done <= 1'b1;
                     state     <= DONE;
`endif
                  end else begin
                     tx_data <= snapshot[{idx_nxt, 3'b000} +: 8];
                  end
               end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
               if (xfer) begin
                  tx_valid  <= 1'b0;
                  dump_done <= 1'b1;
                  state     <= DONE;
               end
            end
`endif
            DONE: begin
               dump_done <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               busy      <= 1'b0;
               tx_valid  <= 1'b0;
               dump_done <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_register_dump_streamer.sv
// Directed bench for register_dump_streamer; expected length follows REG_DUMP_CHECKSUM_EN.
module tb_register_dump_streamer;

   logic         clock = 1'b0;
   logic         clr_n = 1'b0;
   logic [255:0] all_registers = '0;
   logic         dump_req = 1'b0;
   logic         busy;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready = 1'b0;
   logic         dump_done;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [7:0] exp_q[$];

   register_dump_streamer #(.SYNC_BYTE(8'hA5)) dut (
      .clock(clock), .clr_n(clr_n), .all_registers(all_registers),
      .dump_req(dump_req), .busy(busy), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .dump_done(dump_done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Loads all_registers with R(n) = base + n*step and builds the expected stream.
   task automatic load_regs(input logic [7:0] base, input logic [7:0] step);
      logic [7:0] sum;
      logic [7:0] b;
      sum = 8'h00;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      for (int n = 0; n < 32; n++) begin
         b = base + 8'(n) * step;
         all_registers[8*n +: 8] = b;
         exp_q.push_back(b);
         sum = sum + b;
      end
`ifdef REG_DUMP_CHECKSUM_EN
      exp_q.push_back(sum);
`endif
   endtask

   // Called one step after E0; consumes the dump until dump_done is seen.
   task automatic stream(input int period, input logic flood);
      int n = 0;
      int cyc = 1;
      int done_cyc = -1;
      logic stall = 1'b0;
      logic [7:0] held = 8'h00;
      if (flood) all_registers = '1;
      while (cyc < 400 && done_cyc < 0) begin
         tx_ready = (period <= 1) ? 1'b1 : ((cyc % period) == 0);
         if (stall) begin
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_data", 32'(tx_data), 32'(held));
         end
         if (dump_done) done_cyc = cyc;
         else begin
            chk("busy_mid", 32'(busy), 32'd1);
            if (tx_valid && tx_ready) begin
               if (n < exp_q.size()) chk($sformatf("byte%0d", n), 32'(tx_data), 32'(exp_q[n]));
               n++;
            end
            stall = tx_valid && !tx_ready;
            held  = tx_data;
            @(posedge clock); #1;
            cyc++;
         end
      end
      chk("byte_count", 32'(n), 32'(exp_q.size()));
      chk("done_seen", 32'(done_cyc > 0), 32'd1);
      if (period <= 1) chk("done_cycle", 32'(done_cyc), 32'(exp_q.size() + 1));
      chk("busy_in_done", 32'(busy), 32'd1);
      chk("valid_in_done", 32'(tx_valid), 32'd0);
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_data", 32'(tx_data), 32'h00);
      chk("rst_done", 32'(dump_done), 32'd0);
      @(posedge clock); #1;
      clr_n = 1'b1;
      load_regs(8'h10, 8'h01);
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(tx_valid), 32'd0);

      // streaming with ready held high
      dump_req = 1'b1;
      @(posedge clock); #1;
      dump_req = 1'b0;
      stream(1, 1'b0);
      @(posedge clock); #1;
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_done", 32'(dump_done), 32'd0);
      chk("post_valid", 32'(tx_valid), 32'd0);

      // backpressure plus snapshot isolation
      load_regs(8'h10, 8'h01);
      dump_req = 1'b1;
      @(posedge clock); #1;
      dump_req = 1'b0;
      stream(3, 1'b1);
      @(posedge clock); #1;

      // reset mid-dump after R9 transfers
      load_regs(8'h03, 8'h07);
      tx_ready = 1'b1;
      dump_req = 1'b1;
      @(posedge clock); #1;
      dump_req = 1'b0;
      for (int k = 0; k < 11; k++) begin @(posedge clock); #1; end
      chk("pre_rst_r10", 32'(tx_data), 32'(exp_q[11]));
      #2 clr_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valid", 32'(tx_valid), 32'd0);
      chk("mid_rst_data", 32'(tx_data), 32'h00);
      for (int k = 0; k < 3; k++) begin
         @(posedge clock); #1;
         chk("mid_rst_nodone", 32'(dump_done), 32'd0);
      end
      clr_n = 1'b1;
      @(posedge clock); #1;
      chk("after_rst_idle", 32'(tx_valid), 32'd0);
      dump_req = 1'b1;
      @(posedge clock); #1;
      dump_req = 1'b0;
      stream(1, 1'b0);
      @(posedge clock); #1;

      // request held high through a whole dump
      load_regs(8'hC0, 8'h05);
      dump_req = 1'b1;
      @(posedge clock); #1;
      stream(1, 1'b0);
      @(posedge clock); #1;
      chk("held_idle_valid", 32'(tx_valid), 32'd0);
      chk("held_idle_busy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      chk("held_resync_valid", 32'(tx_valid), 32'd1);
      chk("held_resync_data", 32'(tx_data), 32'hA5);
      dump_req = 1'b0;
      stream(1, 1'b0);
      @(posedge clock); #1;
      chk("final_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
